// File: rtl/boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// boot_sequencer_if
//
// Purpose:
//   Groups the two memory-side buses of the boot sequencer: the read port of
//   the registered boot ROM and the write port of instruction memory.
//
// Signals:
//   rom_addr    ADDR_W  boot ROM word address (driven by the sequencer)
//   rom_data    DATA_W  boot ROM read data, one cycle after rom_addr
//   imem_we     1       instruction-memory write request
//   imem_addr   ADDR_W  instruction-memory write address
//   imem_wdata  DATA_W  instruction-memory write data
//   imem_ready  1       write accepted on an edge where imem_we && imem_ready
//
// Modports:
//   master  the boot sequencer
//   slave   the ROM / instruction-memory side
// -----------------------------------------------------------------------------
interface boot_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              imem_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    input  imem_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    output imem_ready
  );

endinterface

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
//
// Purpose:
//   Bring-up master for the pipelined CPU. After system reset it copies
//   PROG_LEN words from the boot ROM into instruction memory, keeps the CPU
//   reset (RST) low for RST_CYCLES more cycles, then releases it. In RUN a
//   start pulse triggers a full reload.
//
// Parameters:
//   ADDR_W      ROM / instruction-memory word address width
//   DATA_W      instruction word width
//   PROG_LEN    words copied, 1 .. 2**ADDR_W
//   RST_CYCLES  cycles RST stays low after the last write, >= 1
//
// Ports:
//   SysCLK     in   system clock, rising edge
//   SysRST     in   synchronous active-low reset
//   start      in   reboot request, honoured only in RUN
//   bus        --   boot_sequencer_if.master (ROM read + imem write ports)
//   RST        out  CPU reset, active-low, registered
//   busy       out  high while loading or holding the CPU in reset
//   boot_done  out  high only in RUN
//
// Timing (imem_ready tied high): word k is accepted at edge 2k+2, RST rises
// at edge 2*PROG_LEN+RST_CYCLES, counting edge 1 as the first edge with
// SysRST high. Every imem_ready=0 cycle adds one cycle to its word.
// -----------------------------------------------------------------------------
module boot_sequencer #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int PROG_LEN   = 16,
  parameter int RST_CYCLES = 8
) (
  input  logic              SysCLK,
  input  logic              SysRST,
  input  logic              start,
  boot_sequencer_if.master  bus,
  output logic              RST,
  output logic              busy,
  output logic              boot_done
);

  // One spare index bit so PROG_LEN = 2**ADDR_W never wraps the index.
  localparam int IDX_W = ADDR_W + 1;
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    FETCH,
    WRITE,
    HOLD,
    RUN
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rst;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [DATA_W-1:0] r_imem_wdata;
  logic              r_boot_done;

  logic [IDX_W-1:0]  w_idx_inc;
  logic              w_last;
  logic              w_accept;
  logic [ADDR_W-1:0] w_rom_addr;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_last    = (r_idx == LAST_IDX);
  assign w_accept  = r_imem_we && bus.imem_ready;

  // ROM address look-ahead.
  // The ROM is registered: the word captured on a FETCH edge is the one the
  // ROM was addressed with on the edge before. So on every edge that enters
  // FETCH (reset, accepting a non-last word, start in RUN) the address must
  // already point at the word FETCH will capture. That is why WRITE shows
  // idx+1, HOLD/RUN show 0, and reset forces 0 combinationally -- a one-cycle
  // reset pulse mid-load still primes word 0 for the first FETCH.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rom_addr = '0;
    if (SysRST) begin
      case (r_state)
        FETCH:   w_rom_addr = r_idx[ADDR_W-1:0];
        WRITE:   if (!w_last) w_rom_addr = w_idx_inc[ADDR_W-1:0];
        default: w_rom_addr = '0;
      endcase
    end
  end

  // Sequencer FSM with registered outputs.
  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge SysCLK) begin
    if (!SysRST) begin
      r_state      <= FETCH;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_rst        <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_boot_done  <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_imem_wdata <= bus.rom_data;
          r_imem_addr  <= r_idx[ADDR_W-1:0];
          r_imem_we    <= 1'b1;
          r_state      <= WRITE;
        end

        WRITE: begin
          // Address, data and request are held untouched while stalled.
          if (w_accept) begin
            r_imem_we <= 1'b0;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_idx   <= w_idx_inc;
              r_state <= FETCH;
            end
          end
        end

        HOLD: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_rst       <= 1'b1;
            r_boot_done <= 1'b1;
            r_state     <= RUN;
          end
        end

        RUN: begin
          // start outside RUN is dropped, never remembered.
          if (start) begin
            r_rst       <= 1'b0;
            r_boot_done <= 1'b0;
            r_idx       <= '0;
            r_state     <= FETCH;
          end
        end

        default: r_state <= FETCH;
      endcase
    end
  end

  assign bus.rom_addr   = w_rom_addr;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;

  assign RST       = r_rst;
  assign boot_done = r_boot_done;
  assign busy      = (r_state != RUN);

  // The CPU only leaves reset in RUN, and never while a write is pending.
  a_rst_only_in_run : assert property (
    @(posedge SysCLK) r_rst |-> ((r_state == RUN) && !r_imem_we)
  );

endmodule
